// File: rtl/apple1_mem_pkg.sv
// Shared types and default constants for the Apple-1 memory arbiter and its eraser.
package apple1_mem_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] ERASE_END_DEFAULT   = 16'hBFFF;
    localparam logic [DATA_W-1:0] ERASE_VALUE_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } erase_state_e;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_DL    = 2'd1,
        GNT_ERASE = 2'd2,
        GNT_CPU   = 2'd3
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wr;
    } ram_req_t;

endpackage

// File: rtl/mem_eraser.sv
// Memory sweeper: writes ERASE_VALUE from 0 up to ERASE_END, one address per granted cycle.
// Only built when MEM_ARBITER_ERASER_EN is defined.
`ifdef MEM_ARBITER_ERASER_EN
module mem_eraser
    import apple1_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ERASE_END   = ERASE_END_DEFAULT,
    parameter logic [DATA_W-1:0] ERASE_VALUE = ERASE_VALUE_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic              advance,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    erase_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Counter only moves when the arbiter actually gave us the RAM this cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (advance) begin
                    if (cnt_q == ERASE_END) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req  = (state_q == SWEEP);
    assign busy = (state_q == SWEEP);
    assign addr = cnt_q;
    assign data = ERASE_VALUE;

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: downloader > eraser > CPU, with a one-cycle CPU read hold/bypass.
// Define MEM_ARBITER_ERASER_EN to include the mem_eraser sweeper.
module mem_arbiter
    import apple1_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ERASE_END   = ERASE_END_DEFAULT,
    parameter logic [DATA_W-1:0] ERASE_VALUE = ERASE_VALUE_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [DATA_W-1:0] dl_data,
    output logic              dl_ack,
    input  logic              cpu_clken,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_stall,
    input  logic              erase_start,
    output logic              erase_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wr,
    output logic              ram_ena,
    input  logic [DATA_W-1:0] ram_dout
);

    grant_e            gnt_c;
    ram_req_t          req_c;
    logic              cpu_valid_c;
    logic              er_req;
    logic              er_busy;
    logic              er_advance;
    logic [ADDR_W-1:0] er_addr;
    logic [DATA_W-1:0] er_data;
    logic              rd_pending_q, rd_pending_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    assign cpu_valid_c = cpu_clken & (cpu_rd | cpu_wr);
    assign er_advance  = (gnt_c == GNT_ERASE);

`ifdef MEM_ARBITER_ERASER_EN
    mem_eraser #(
        .ERASE_END   (ERASE_END),
        .ERASE_VALUE (ERASE_VALUE)
    ) u_eraser (
        .clk_sys (clk_sys),
        .reset   (reset),
        .start   (erase_start),
        .advance (er_advance),
        .req     (er_req),
        .addr    (er_addr),
        .data    (er_data),
        .busy    (er_busy)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{erase_start, ERASE_END, ERASE_VALUE, er_advance};
    assign er_req     = 1'b0;
    assign er_busy    = 1'b0;
    assign er_addr    = '0;
    assign er_data    = '0;
`endif

    // Fixed priority; nobody owns the RAM while reset is held.
    always_comb begin
        gnt_c = GNT_NONE;
        if (reset) begin
            gnt_c = GNT_NONE;
        end else if (dl_req) begin
            gnt_c = GNT_DL;
        end else if (er_req) begin
            gnt_c = GNT_ERASE;
        end else if (cpu_valid_c) begin
            gnt_c = GNT_CPU;
        end
    end

    always_comb begin
        req_c = '0;
        case (gnt_c)
            GNT_DL:    req_c = '{addr: dl_addr,  data: dl_data,  wr: 1'b1};
            GNT_ERASE: req_c = '{addr: er_addr,  data: er_data,  wr: 1'b1};
            GNT_CPU:   req_c = '{addr: cpu_addr, data: cpu_dout, wr: cpu_wr};
            default:   req_c = '0;
        endcase
    end

    assign ram_addr   = req_c.addr;
    assign ram_din    = req_c.data;
    assign ram_wr     = req_c.wr;
    assign ram_ena    = (gnt_c != GNT_NONE);
    assign dl_ack     = (gnt_c == GNT_DL);
    assign erase_busy = er_busy;
    assign cpu_stall  = er_busy | (cpu_valid_c & (gnt_c != GNT_CPU));

    // RAM data lands one cycle after a granted read; capture it so later cycles keep it.
    always_comb begin
        rd_pending_d = (gnt_c == GNT_CPU) & ~cpu_wr;
        hold_d       = rd_pending_q ? ram_dout : hold_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_pending_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            rd_pending_q <= rd_pending_d;
            hold_q       <= hold_d;
        end
    end

    assign cpu_din = rd_pending_q ? ram_dout : hold_q;

endmodule
